layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised N-layer priority pixel compositor for the VGA path; successor to the fixed 4-input object mux.
- Per pixel, selects the highest-priority enabled, non-transparent layer, or the background when no layer qualifies.
- Layer enables update only at frame boundaries.
- Accumulates per-layer overlap (collision) flags over each frame for game logic (ball/hole/ball contact).

Parameters:
- NUM_LAYERS, 8, number of object layers; index 0 = highest priority.
- RGB_W, 8, pixel colour width.
- TRANSPARENT, 8'hFF, colour key; a layer pixel equal to it never wins and never collides.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- pixel_valid  in  1  active-video pixel present this cycle.
- start_of_frame  in  1  one-cycle pulse, coincident with the first pixel of a frame.
- layer_req  in  NUM_LAYERS  per-layer drawing request.
- layer_rgb  in  NUM_LAYERS*RGB_W  packed layer colours; layer i at [i*RGB_W +: RGB_W].
- backGroundRGB  in  RGB_W  background colour.
- layer_en_in  in  NUM_LAYERS  requested layer enables; sampled only at start_of_frame.
- RGBOut  out  RGB_W  composited pixel.
- rgb_valid  out  1  RGBOut is valid.
- winner_idx  out  $clog2(NUM_LAYERS)  index of the winning layer; 0 when no layer wins.
- winner_hit  out  1  a layer won (1) or background was used (0).
- collision_mask  out  NUM_LAYERS  layers that overlapped another qualified layer during the previous frame.
- collision_valid  out  1  one-cycle pulse when collision_mask updates.

Behaviour:
- Reset (synchronous, highest precedence over all other inputs):
  - RGBOut=0, rgb_valid=0, winner_idx=0, winner_hit=0, collision_mask=0, collision_valid=0.
  - Enable shadow = all ones; collision accumulator = 0; pipeline valid bits = 0.
- Enable selection: en_cur = layer_en_in when start_of_frame=1, otherwise the enable shadow. The shadow loads layer_en_in on every start_of_frame cycle.
- Qualification: q[i] = pixel_valid & layer_req[i] & en_cur[i] & (layer_rgb[i] != TRANSPARENT).
- Stage 1 (registered): q, layer_rgb, backGroundRGB, pixel_valid.
- Stage 2 (registered):
  - Priority-encode the lowest set index of the stage-1 q.
  - If any bit is set: RGBOut = that layer's rgb, winner_hit=1, winner_idx=index.
  - Otherwise: RGBOut = background, winner_hit=0, winner_idx=0.
  - rgb_valid = stage-1 valid.
- Latency: exactly 2 cycles from pixel_valid to rgb_valid; throughput 1 pixel/cycle; no back-pressure.
- pixel_valid=0 (blanking): the bubble propagates; at stage 2, rgb_valid=0, RGBOut=0, winner_hit=0, winner_idx=0.
- Collision accumulation: if popcount(q) >= 2 in a cycle, acc |= q.
- On start_of_frame:
  - collision_mask <= acc as accumulated through the previous cycle.
  - collision_valid = 1 on the following cycle, for one cycle.
  - acc <= collision contribution of the current (first) pixel only.
- Back-to-back start_of_frame pulses: each publishes; an empty frame publishes 0.
- Simultaneous start_of_frame and pixel_valid=0: enable load and publication still occur.
- collision_mask holds its value between publications.
- Reset mid-frame: pipeline contents are discarded; the first frame after reset publishes only collisions seen since reset.

Optional Feature:
- Macro: LAYER_COMPOSITOR_COLLISION_EN.
- Defined: collision accumulation and publication as above.
- Undefined: no accumulator logic is built; collision_mask is tied to 0 and collision_valid to 0; ports remain present.

Decomposition:
- compositor_pkg holds:
  - default NUM_LAYERS and RGB_W;
  - the TRANSPARENT_DEFAULT constant;
  - typedef layer_idx_t (logic [$clog2(NUM_LAYERS)-1:0]);
  - typedef layer_mask_t.
- One sub-module: prio_encoder (parameter N; input mask; outputs idx and hit; combinational, lowest index wins), instantiated in stage 2.

Test Plan (NUM_LAYERS=4, TRANSPARENT=8'hFF, all enables=1 unless stated):
- Priority: req=4'b1010, rgb1=8'h1C, rgb3=8'hE0, pixel_valid=1 -> 2 cycles later RGBOut=8'h1C, winner_idx=1, winner_hit=1, rgb_valid=1.
- Transparency: req=4'b0011, rgb0=8'hFF, rgb1=8'h03 -> RGBOut=8'h03, winner_idx=1; then req=0001 with rgb0=8'hFF, background=8'h24 -> RGBOut=8'h24, winner_hit=0.
- Frame-synchronous enable: drive layer_en_in=4'b1110 mid-frame with req=0001, rgb0=8'h55 -> layer 0 still wins until start_of_frame; from that pixel on, background is output.
- Collision: frame with one pixel req=4'b0101 (non-transparent) and other pixels single-layer -> at next start_of_frame, collision_mask=4'b0101 and collision_valid pulses once; following empty frame publishes 4'b0000.
- Blanking/latency: pixel_valid pattern 1,0,1 -> rgb_valid pattern 1,0,1 delayed by 2 cycles; RGBOut=0 in the bubble.
- Reset mid-stream: assert reset for 1 cycle during active pixels -> next edge all outputs 0, collision_mask=0, enables restored to all ones; normal output resumes 2 cycles after reset deasserts.

Source files
------------

// File: rtl/compositor_pkg.sv
// rtl/compositor_pkg.sv - shared defaults and types for the layer compositor
//
// Purpose: default layer count, colour width and transparent colour key,
//          plus index/mask types sized for the default layer count.
// Ports:   none (package).

package compositor_pkg;

    localparam int         NUM_LAYERS_DEFAULT  = 8;
    localparam int         RGB_W_DEFAULT       = 8;
    localparam logic [7:0] TRANSPARENT_DEFAULT = 8'hFF;

    typedef logic [$clog2(NUM_LAYERS_DEFAULT)-1:0] layer_idx_t;
    typedef logic [NUM_LAYERS_DEFAULT-1:0]         layer_mask_t;

endpackage

// File: rtl/layer_compositor_prio_encoder.sv
// rtl/layer_compositor_prio_encoder.sv - combinational lowest-index priority encoder
//
// Purpose: report the lowest set bit of a request mask.
// Ports:
//   mask  in   N      request bits, bit 0 has the highest priority
//   idx   out  IW     index of the lowest set bit, 0 when none is set
//   hit   out  1      at least one bit of mask is set

module prio_encoder #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          hit
);

    // Scan from the top down so the lowest set index is the last to assign.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IW'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer priority pixel compositor with collision flags
//
// Purpose: per pixel, output the colour of the highest-priority enabled,
//          non-transparent layer (index 0 highest), else the background.
//          Two-stage pipeline, one pixel per cycle. Layer enables change only
//          at start_of_frame. With LAYER_COMPOSITOR_COLLISION_EN defined, the
//          layers that overlapped during a frame are published at the next
//          start_of_frame; otherwise collision_mask/collision_valid read 0.
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   pixel_valid       active-video pixel this cycle
//   start_of_frame    pulse on the first pixel of a frame
//   layer_req         per-layer drawing request
//   layer_rgb         packed layer colours, layer i at [i*RGB_W +: RGB_W]
//   backGroundRGB     background colour
//   layer_en_in       requested enables, taken at start_of_frame
//   RGBOut/rgb_valid  composited pixel, two cycles after pixel_valid
//   winner_idx/hit    winning layer index / a layer won
//   collision_mask    layers that overlapped during the previous frame
//   collision_valid   pulse when collision_mask updates

module layer_compositor
    import compositor_pkg::*;
#(
    parameter int               NUM_LAYERS  = NUM_LAYERS_DEFAULT,
    parameter int               RGB_W       = RGB_W_DEFAULT,
    parameter logic [RGB_W-1:0] TRANSPARENT = RGB_W'(TRANSPARENT_DEFAULT),
    parameter int               IDX_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pixel_valid,
    input  logic                        start_of_frame,
    input  logic [NUM_LAYERS-1:0]       layer_req,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            backGroundRGB,
    input  logic [NUM_LAYERS-1:0]       layer_en_in,
    output logic [RGB_W-1:0]            RGBOut,
    output logic                        rgb_valid,
    output logic [IDX_W-1:0]            winner_idx,
    output logic                        winner_hit,
    output logic [NUM_LAYERS-1:0]       collision_mask,
    output logic                        collision_valid
);

    logic [NUM_LAYERS-1:0]       en_shadow_q, en_shadow_d;
    logic [NUM_LAYERS-1:0]       en_cur;
    logic [NUM_LAYERS-1:0]       qual;

    logic [NUM_LAYERS-1:0]       s1_qual_q, s1_qual_d;
    logic [NUM_LAYERS*RGB_W-1:0] s1_rgb_q, s1_rgb_d;
    logic [RGB_W-1:0]            s1_bg_q, s1_bg_d;
    logic                        s1_valid_q, s1_valid_d;

    logic [RGB_W-1:0]            rgb_out_q, rgb_out_d;
    logic                        rgb_valid_q, rgb_valid_d;
    logic [IDX_W-1:0]            winner_idx_q, winner_idx_d;
    logic                        winner_hit_q, winner_hit_d;

    logic [IDX_W-1:0]            enc_idx;
    logic                        enc_hit;

    // The first pixel of a frame already uses the new enables.
    always_comb begin
        en_cur      = start_of_frame ? layer_en_in : en_shadow_q;
        en_shadow_d = start_of_frame ? layer_en_in : en_shadow_q;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            qual[i] = pixel_valid & layer_req[i] & en_cur[i]
                    & (layer_rgb[i*RGB_W +: RGB_W] != TRANSPARENT);
        end
    end

    always_comb begin
        s1_qual_d  = qual;
        s1_rgb_d   = layer_rgb;
        s1_bg_d    = backGroundRGB;
        s1_valid_d = pixel_valid;
    end

    prio_encoder #(
        .N  (NUM_LAYERS),
        .IW (IDX_W)
    ) u_prio (
        .mask (s1_qual_q),
        .idx  (enc_idx),
        .hit  (enc_hit)
    );

    // Blanking pixels produce all-zero outputs rather than the background.
    always_comb begin
        rgb_out_d    = '0;
        winner_idx_d = '0;
        winner_hit_d = 1'b0;
        rgb_valid_d  = s1_valid_q;
        if (s1_valid_q) begin
            if (enc_hit) begin
                rgb_out_d    = s1_rgb_q[int'(enc_idx)*RGB_W +: RGB_W];
                winner_idx_d = enc_idx;
                winner_hit_d = 1'b1;
            end else begin
                rgb_out_d = s1_bg_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_shadow_q  <= '1;
            s1_qual_q    <= '0;
            s1_rgb_q     <= '0;
            s1_bg_q      <= '0;
            s1_valid_q   <= 1'b0;
            rgb_out_q    <= '0;
            rgb_valid_q  <= 1'b0;
            winner_idx_q <= '0;
            winner_hit_q <= 1'b0;
        end else begin
            en_shadow_q  <= en_shadow_d;
            s1_qual_q    <= s1_qual_d;
            s1_rgb_q     <= s1_rgb_d;
            s1_bg_q      <= s1_bg_d;
            s1_valid_q   <= s1_valid_d;
            rgb_out_q    <= rgb_out_d;
            rgb_valid_q  <= rgb_valid_d;
            winner_idx_q <= winner_idx_d;
            winner_hit_q <= winner_hit_d;
        end
    end

    assign RGBOut     = rgb_out_q;
    assign rgb_valid  = rgb_valid_q;
    assign winner_idx = winner_idx_q;
    assign winner_hit = winner_hit_q;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
    logic [NUM_LAYERS-1:0] acc_q, acc_d;
    logic [NUM_LAYERS-1:0] coll_mask_q, coll_mask_d;
    logic                  coll_valid_q, coll_valid_d;
    logic [NUM_LAYERS-1:0] contrib;

    // x & (x-1) clears the lowest set bit, so non-zero means two or more layers.
    always_comb begin
        contrib      = ((qual & (qual - NUM_LAYERS'(1))) != '0) ? qual : '0;
        acc_d        = start_of_frame ? contrib : (acc_q | contrib);
        coll_mask_d  = start_of_frame ? acc_q : coll_mask_q;
        coll_valid_d = start_of_frame;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            coll_mask_q  <= '0;
            coll_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            coll_mask_q  <= coll_mask_d;
            coll_valid_q <= coll_valid_d;
        end
    end

    assign collision_mask  = coll_mask_q;
    assign collision_valid = coll_valid_q;
`else
    assign collision_mask  = '0;
    assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - self-checking bench for layer_compositor

module tb_layer_compositor;

    localparam int N = 4;
    localparam int W = 8;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           pixel_valid;
    logic           start_of_frame;
    logic [N-1:0]   layer_req;
    logic [N*W-1:0] layer_rgb;
    logic [W-1:0]   bg_rgb;
    logic [N-1:0]   layer_en_in;
    logic [W-1:0]   rgb_out;
    logic           rgb_valid;
    logic [1:0]     winner_idx;
    logic           winner_hit;
    logic [N-1:0]   collision_mask;
    logic           collision_valid;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS  (N),
        .RGB_W       (W),
        .TRANSPARENT (8'hFF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pixel_valid     (pixel_valid),
        .start_of_frame  (start_of_frame),
        .layer_req       (layer_req),
        .layer_rgb       (layer_rgb),
        .backGroundRGB   (bg_rgb),
        .layer_en_in     (layer_en_in),
        .RGBOut          (rgb_out),
        .rgb_valid       (rgb_valid),
        .winner_idx      (winner_idx),
        .winner_hit      (winner_hit),
        .collision_mask  (collision_mask),
        .collision_valid (collision_valid)
    );

    typedef struct {
        logic [W-1:0] rgb;
        logic [1:0]   idx;
        logic         hit;
        logic         valid;
        string        name;
    } pix_t;

    typedef struct {
        logic         sof;
        logic         pv;
        logic [N-1:0] req;
        logic [N-1:0] en;
        logic [N*W-1:0] rgb;
        logic [W-1:0] e_rgb;
        logic [1:0]   e_idx;
        logic         e_hit;
        logic         e_valid;
    } vec_t;

    pix_t         exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [N-1:0] m_en  = '1;
    logic [N-1:0] m_acc = '0;
    logic [N-1:0] m_mask = '0;
    logic         m_cv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: which layers draw a visible, enabled pixel.
    function automatic logic [N-1:0] model_qual(input logic sof, input logic pv,
                                                input logic [N-1:0] req, input logic [N-1:0] en,
                                                input logic [N*W-1:0] rgb);
        logic [N-1:0] en_use;
        logic [N-1:0] q;
        en_use = sof ? en : m_en;
        for (int i = 0; i < N; i++)
            q[i] = pv && req[i] && en_use[i] && (rgb[i*W +: W] != 8'hFF);
        return q;
    endfunction

    function automatic pix_t model_pix(input logic pv, input logic [N-1:0] q,
                                       input logic [N*W-1:0] rgb, input logic [W-1:0] bgc,
                                       input string name);
        pix_t p;
        p.rgb = '0; p.idx = '0; p.hit = 1'b0; p.valid = pv; p.name = name;
        if (pv) begin
            p.rgb = bgc;
            for (int i = N - 1; i >= 0; i--)
                if (q[i]) begin
                    p.rgb = rgb[i*W +: W];
                    p.idx = 2'(i);
                    p.hit = 1'b1;
                end
        end
        return p;
    endfunction

    // One pixel clock: drive, update the reference, then check outputs after the edge.
    task automatic step(input logic rst, input logic sof, input logic pv,
                        input logic [N-1:0] req, input logic [N-1:0] en,
                        input logic [N*W-1:0] rgb, input logic [W-1:0] bgc,
                        input bit use_exp, input pix_t texp, input string name);
        pix_t         z;
        pix_t         e;
        logic [N-1:0] q;
        logic [N-1:0] contrib;
        reset = rst; start_of_frame = sof; pixel_valid = pv;
        layer_req = req; layer_en_in = en; layer_rgb = rgb; bg_rgb = bgc;
        z.rgb = '0; z.idx = '0; z.hit = 1'b0; z.valid = 1'b0; z.name = "rst";
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(z);
            exp_q.push_back(z);
            m_en = '1; m_acc = '0; m_mask = '0; m_cv = 1'b0;
        end else begin
            q = model_qual(sof, pv, req, en, rgb);
            exp_q.push_back(use_exp ? texp : model_pix(pv, q, rgb, bgc, name));
            contrib = ($countones(q) >= 2) ? q : '0;
            if (sof) begin
                m_mask = m_acc; m_cv = 1'b1; m_acc = contrib; m_en = en;
            end else begin
                m_cv = 1'b0; m_acc = m_acc | contrib;
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk({e.name, ".rgb"},   32'(rgb_out),    32'(e.rgb));
            chk({e.name, ".idx"},   32'(winner_idx), 32'(e.idx));
            chk({e.name, ".hit"},   32'(winner_hit), 32'(e.hit));
            chk({e.name, ".valid"}, 32'(rgb_valid),  32'(e.valid));
        end
        chk({name, ".cmask"},  32'(collision_mask),  COLL_EN ? 32'(m_mask) : 32'd0);
        chk({name, ".cvalid"}, 32'(collision_valid), COLL_EN ? 32'(m_cv)   : 32'd0);
    endtask

    task automatic px(input logic sof, input logic pv, input logic [N-1:0] req,
                      input logic [N-1:0] en, input logic [N*W-1:0] rgb, input string name);
        pix_t d;
        d.rgb = '0; d.idx = '0; d.hit = 1'b0; d.valid = 1'b0; d.name = name;
        step(1'b0, sof, pv, req, en, rgb, 8'h24, 1'b0, d, name);
    endtask

    vec_t tab[10];

    initial begin
        pix_t         t;
        logic [N*W-1:0] r;

        tab[0] = '{1'b1, 1'b1, 4'b1010, 4'b1111, {8'hE0, 8'h00, 8'h1C, 8'h00}, 8'h1C, 2'd1, 1'b1, 1'b1};
        tab[1] = '{1'b0, 1'b1, 4'b0011, 4'b1111, {8'h00, 8'h00, 8'h03, 8'hFF}, 8'h03, 2'd1, 1'b1, 1'b1};
        tab[2] = '{1'b0, 1'b1, 4'b0001, 4'b1111, {8'h00, 8'h00, 8'h00, 8'hFF}, 8'h24, 2'd0, 1'b0, 1'b1};
        tab[3] = '{1'b0, 1'b1, 4'b0101, 4'b1111, {8'h00, 8'h20, 8'h00, 8'h10}, 8'h10, 2'd0, 1'b1, 1'b1};
        tab[4] = '{1'b0, 1'b0, 4'b1111, 4'b1111, {8'h11, 8'h11, 8'h11, 8'h11}, 8'h00, 2'd0, 1'b0, 1'b0};
        tab[5] = '{1'b0, 1'b1, 4'b1000, 4'b1111, {8'h33, 8'h00, 8'h00, 8'h00}, 8'h33, 2'd3, 1'b1, 1'b1};
        tab[6] = '{1'b0, 1'b1, 4'b0001, 4'b1110, {8'h00, 8'h00, 8'h00, 8'h55}, 8'h55, 2'd0, 1'b1, 1'b1};
        tab[7] = '{1'b1, 1'b1, 4'b0001, 4'b1110, {8'h00, 8'h00, 8'h00, 8'h55}, 8'h24, 2'd0, 1'b0, 1'b1};
        tab[8] = '{1'b1, 1'b0, 4'b0000, 4'b1111, {8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 2'd0, 1'b0, 1'b0};
        tab[9] = '{1'b0, 1'b1, 4'b0010, 4'b0000, {8'h00, 8'h00, 8'h1C, 8'h00}, 8'h1C, 2'd1, 1'b1, 1'b1};

        t.rgb = '0; t.idx = '0; t.hit = 1'b0; t.valid = 1'b0; t.name = "init";
        step(1'b1, 1'b0, 1'b0, '0, '1, '0, 8'h24, 1'b0, t, "reset0");
        step(1'b1, 1'b0, 1'b0, '0, '1, '0, 8'h24, 1'b0, t, "reset1");

        // Table vectors: priority, transparency, blanking, frame-synchronous enables.
        for (int v = 0; v < 10; v++) begin
            t.rgb = tab[v].e_rgb; t.idx = tab[v].e_idx; t.hit = tab[v].e_hit;
            t.valid = tab[v].e_valid; t.name = $sformatf("vec%0d", v);
            step(1'b0, tab[v].sof, tab[v].pv, tab[v].req, tab[v].en, tab[v].rgb,
                 8'h24, 1'b1, t, t.name);
        end
        px(1'b0, 1'b0, '0, '1, '0, "flush0");
        px(1'b0, 1'b0, '0, '1, '0, "flush1");

        // Collision frame: one overlapping pixel, then single-layer pixels.
        px(1'b1, 1'b1, 4'b0101, 4'b1111, {8'h00, 8'h02, 8'h00, 8'h01}, "coll_a");
        px(1'b0, 1'b1, 4'b0001, 4'b1111, {8'h00, 8'h00, 8'h00, 8'h01}, "coll_b");
        px(1'b0, 1'b1, 4'b0100, 4'b1111, {8'h00, 8'h02, 8'h00, 8'h00}, "coll_c");
        px(1'b1, 1'b1, 4'b0001, 4'b1111, {8'h00, 8'h00, 8'h00, 8'h01}, "coll_pub");
        chk("coll_pub_mask",  32'(collision_mask),  COLL_EN ? 32'h5 : 32'h0);
        chk("coll_pub_valid", 32'(collision_valid), COLL_EN ? 32'h1 : 32'h0);
        px(1'b0, 1'b1, 4'b0001, 4'b1111, {8'h00, 8'h00, 8'h00, 8'h01}, "coll_hold");
        chk("coll_pulse_once", 32'(collision_valid), 32'h0);
        chk("coll_hold_mask",  32'(collision_mask),  COLL_EN ? 32'h5 : 32'h0);
        px(1'b1, 1'b0, 4'b0000, 4'b1111, '0, "coll_empty");
        px(1'b1, 1'b0, 4'b0000, 4'b1111, '0, "coll_empty2");
        chk("coll_empty_mask", 32'(collision_mask), 32'h0);

        // Reset mid-stream with layer 0 disabled; reset restores all enables.
        px(1'b1, 1'b1, 4'b0101, 4'b0000, {8'h00, 8'h02, 8'h00, 8'h77}, "rst_a");
        px(1'b0, 1'b1, 4'b0101, 4'b1111, {8'h00, 8'h02, 8'h00, 8'h77}, "rst_b");
        step(1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h77},
             8'h24, 1'b0, t, "rst_mid");
        chk("rst_rgb",   32'(rgb_out),        32'h0);
        chk("rst_valid", 32'(rgb_valid),      32'h0);
        chk("rst_cmask", 32'(collision_mask), 32'h0);
        px(1'b0, 1'b1, 4'b0101, 4'b0000, {8'h00, 8'h02, 8'h00, 8'h77}, "rst_c");
        px(1'b0, 1'b1, 4'b0001, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h77}, "rst_d");
        chk("rst_resume_rgb", 32'(rgb_out), 32'h77);
        px(1'b1, 1'b0, '0, 4'b1111, '0, "rst_pub");

        // Randomised traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++)
                r[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), r,
                 8'($urandom), 1'b0, t, $sformatf("rnd%0d", k));
        end
        px(1'b0, 1'b0, '0, '1, '0, "tail0");
        px(1'b0, 1'b0, '0, '1, '0, "tail1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
